// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 write-path arbiter.
package axi4_pkg;

    localparam int unsigned AXLEN_W  = 8;
    localparam int unsigned AXSIZE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/axi4_rr_arbiter.sv
// Rotating-priority pick: first requester at or after ptr, wrapping around.
// Purely combinational.
module axi4_rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int unsigned      w_idx;
    logic [IDX_W-1:0] w_sel;

    // Scan candidates in priority order starting at ptr; keep the first hit
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_idx = (32'(ptr) + 32'(k)) % 32'(NUM_M);
            w_sel = IDX_W'(w_idx);
            if (!gnt_vld && req[w_sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_sel;
            end
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path (AW/W/B) among NUM_M masters.
// One whole transaction (address, burst, response) is granted at a time.
// Optional: define AXI4_WR_ARB_STATS_EN to add per-master completion counters (grant_cnt).
module axi4_wr_arbiter
    import axi4_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(NUM_M)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_M-1:0]          s_awvalid,
    output logic [NUM_M-1:0]          s_awready,
    input  logic [NUM_M*ADDR_W-1:0]   s_awaddr,
    input  logic [NUM_M*AXLEN_W-1:0]  s_awlen,
    input  logic [NUM_M*AXSIZE_W-1:0] s_awsize,
    input  logic [NUM_M-1:0]          s_wvalid,
    output logic [NUM_M-1:0]          s_wready,
    input  logic [NUM_M*DATA_W-1:0]   s_wdata,
    input  logic [NUM_M-1:0]          s_wlast,
    output logic [NUM_M-1:0]          s_bvalid,
    input  logic [NUM_M-1:0]          s_bready,
    output logic [NUM_M*2-1:0]        s_bresp,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic [AXLEN_W-1:0]        m_awlen,
    output logic [AXSIZE_W-1:0]       m_awsize,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_W-1:0]         m_wdata,
    output logic                      m_wlast,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [1:0]                m_bresp,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      wlast_err
`ifdef AXI4_WR_ARB_STATS_EN
    ,
    output logic [NUM_M*16-1:0]       grant_cnt
`endif
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_ptr;
    logic [AXLEN_W-1:0] r_len;
    logic [AXLEN_W-1:0] r_beat;
    logic               r_err;

    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    int unsigned        w_g;

    axi4_rr_arbiter #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (s_awvalid),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    assign w_g       = 32'(r_grant);
    assign w_aw_hs   = (r_state == ADDR) && m_awvalid && m_awready;
    assign w_w_hs    = (r_state == DATA) && m_wvalid && m_wready;
    assign w_b_hs    = (r_state == RESP) && m_bvalid && m_bready;
    assign w_ptr_nxt = (r_grant == IDX_W'(NUM_M - 1)) ? '0 : r_grant + 1'b1;

    assign grant_id  = r_grant;
    assign busy      = (r_state != IDLE);
    assign wlast_err = r_err;

    // Route only the channel owned by the current phase; everything else stays 0
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        case (r_state)
            ADDR: begin
                m_awvalid          = s_awvalid[r_grant];
                m_awaddr           = s_awaddr[w_g*ADDR_W +: ADDR_W];
                m_awlen            = s_awlen[w_g*AXLEN_W +: AXLEN_W];
                m_awsize           = s_awsize[w_g*AXSIZE_W +: AXSIZE_W];
                s_awready[r_grant] = m_awready;
            end
            DATA: begin
                m_wvalid          = s_wvalid[r_grant];
                m_wdata           = s_wdata[w_g*DATA_W +: DATA_W];
                m_wlast           = s_wlast[r_grant];
                s_wready[r_grant] = m_wready;
            end
            RESP: begin
                s_bvalid[r_grant]   = m_bvalid;
                s_bresp[w_g*2 +: 2] = m_bresp;
                m_bready            = s_bready[r_grant];
            end
            default: ;
        endcase
    end

    // Transaction FSM, beat counter and sticky WLAST-position error
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_grant <= w_gnt_idx;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_aw_hs) begin
                        r_len   <= m_awlen;
                        r_beat  <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + 1'b1;
                        // Error if WLAST arrives early/late, or AWLEN is reached without WLAST
                        if ((r_beat == r_len) != m_wlast) begin
                            r_err <= 1'b1;
                        end
                        if (m_wlast) begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AXI4_WR_ARB_STATS_EN
    // Per-master count of completed B handshakes, saturating
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            grant_cnt <= '0;
        end else if (w_b_hs && (grant_cnt[w_g*16 +: 16] != 16'hFFFF)) begin
            grant_cnt[w_g*16 +: 16] <= grant_cnt[w_g*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule
